vector_accum_sched: RTL and testbench
=====================================

# vector_accum_sched

Sequencing controller for the GCN aggregation datapath. It accepts a stream of `WEIGHT_COLS`-element feature vectors (one per neighbour row) under valid/ready handshake and sums them element-wise into an internal accumulator through a per-element adder. After a programmed number of vectors it presents the aggregated vector downstream under its own valid/ready handshake. It sits between the dot-product (weight multiply) stage and the activation/writeback stage, and handles one aggregation job at a time.

## Interface
Parameters:
- `WEIGHT_COLS`, 3, elements per vector.
- `DOT_PROD_WIDTH`, 16, unsigned element width.
- `COUNT_WIDTH`, 5, width of the vector-count field; max job length is 2^COUNT_WIDTH−1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  job start pulse; sampled only in IDLE.
- `num_vecs`  in  COUNT_WIDTH  number of vectors in the job; latched on accepted `start`.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  block can accept an input vector.
- `in_vector`  in  DOT_PROD_WIDTH × [0:WEIGHT_COLS-1]  input vector.
- `out_valid`  out  1  aggregated vector valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_vector`  out  DOT_PROD_WIDTH × [0:WEIGHT_COLS-1]  aggregated vector, driven directly from the accumulator.
- `overflow`  out  1  sticky flag: some element carried out during the current job.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, ACCUM and OUTPUT.
- **IDLE**
  - On `start`=1: clear the accumulator, clear `overflow`, and latch `num_vecs` into the remaining-count register.
  - If `num_vecs`=0, go to OUTPUT; otherwise go to ACCUM.
- **ACCUM**
  - `in_ready`=1.
  - On each beat (`in_valid`&`in_ready`): `acc[i] <= acc[i] + in_vector[i]` for all i, and decrement the remaining count.
  - The beat that takes the count from 1 to 0 moves the FSM to OUTPUT.
  - A cycle with `in_valid`=0 leaves all state unchanged.
- **OUTPUT**
  - `out_valid`=1 and `in_ready`=0.
  - `out_vector` and `overflow` hold stable until the handshake (`out_valid`&`out_ready`).
  - After the handshake the FSM returns to IDLE.
- `start` outside IDLE is ignored; it is neither queued nor allowed to restart the job.
- Arithmetic per element:
  - Unsigned, DOT_PROD_WIDTH-bit, computed as a (DOT_PROD_WIDTH+1)-bit sum.
  - Carry-out sets `overflow` for the rest of the job.
  - The stored value follows the Configuration section.
- A `reset` in the middle of a job aborts it: no output is produced and the partial sum is discarded.

## Timing
- Reset values: state=IDLE, accumulator=0, count=0, `in_ready`=0, `out_valid`=0, `out_vector`=all zeros, `overflow`=0, `busy`=0.
- `start` in cycle T gives ACCUM (or OUTPUT when `num_vecs`=0) in cycle T+1, so `in_ready` rises at T+1.
- Throughput is one vector per cycle while `in_valid` is held high.
- If the last beat is accepted in cycle L, then `out_valid`=1 in L+1 and the sum includes that beat.
- If `num_vecs`=N and input never stalls:
  - `start` at T gives `out_valid` at T+N+1.
  - For N=0, `out_valid` rises at T+1 with a zero vector.
- A handshake at cycle H gives IDLE at H+1, so the earliest next `start` is sampled at H+1.
- Minimum gap between the `out_valid` of job K and the `in_ready` of job K+1 is 2 cycles.
- `in_ready` and `out_valid` are registered-state decodes; neither depends combinationally on `in_valid` or `out_ready`.
- Back-pressure:
  - `out_ready`=0 holds OUTPUT indefinitely.
  - Input arriving during OUTPUT is not accepted, because `in_ready`=0.

## Configuration
- Macro: `VEC_ACC_SAT_EN`.
- Defined:
  - On carry-out an element clamps to 2^DOT_PROD_WIDTH−1.
  - Once saturated, the element stays saturated for the rest of the job.
- Undefined: elements wrap modulo 2^DOT_PROD_WIDTH.
- `overflow` behaves the same in both builds.

## Test plan
- Reset behaviour: reset asserted 3 cycles, then `start`=0 → all outputs hold their reset values, `busy`=0.
- Basic job:
  - Stimulus: `num_vecs`=3 with vectors {1,2,3}, {10,20,30}, {100,200,300}, `in_valid` held high, `out_ready`=1.
  - Required response: `out_vector`={111,222,333}, `overflow`=0, `out_valid` at `start`+4.
- Stalls:
  - Stimulus: `num_vecs`=2 with `in_valid` toggled 1,0,0,1, and `out_ready`=0 for 5 cycles.
  - Required response: the sum is correct; `out_vector` stays stable while stalled; `start` pulses during ACCUM and OUTPUT are ignored.
- Zero-length job: `num_vecs`=0 → `out_valid` one cycle after `start`, `out_vector`={0,0,0}, `in_ready` never rises.
- Overflow:
  - Stimulus: `num_vecs`=2 with vectors {0xFFFF,1,0} and {2,1,0}.
  - Without `VEC_ACC_SAT_EN`: `out_vector`={0x0001,2,0}.
  - With `VEC_ACC_SAT_EN`: `out_vector`={0xFFFF,2,0}.
  - Both builds: `overflow`=1, and it clears on the next `start`.
- Reset mid-job: reset after 2 of 4 beats → IDLE; a new job with `num_vecs`=1 and vector {5,5,5} returns {5,5,5}, with no leftover partial sum.

Source files
------------

// File: rtl/vector_accum_sched_if.sv
// Job/stream handshake bundle for vector_accum_sched.
// master drives jobs and input vectors; slave is the accumulator.
interface vector_accum_sched_if #(
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int COUNT_WIDTH    = 5
);
  logic                                       start;
  logic [COUNT_WIDTH-1:0]                     num_vecs;
  logic                                       in_valid;
  logic                                       in_ready;
  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] in_vector;
  logic                                       out_valid;
  logic                                       out_ready;
  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] out_vector;
  logic                                       overflow;
  logic                                       busy;

  modport master (
    output start, num_vecs, in_valid, in_vector, out_ready,
    input  in_ready, out_valid, out_vector, overflow, busy
  );

  modport slave (
    input  start, num_vecs, in_valid, in_vector, out_ready,
    output in_ready, out_valid, out_vector, overflow, busy
  );
endinterface

// File: rtl/vector_accum_sched.sv
// Element-wise vector accumulator with IDLE/ACCUM/OUTPUT sequencing.
// `VEC_ACC_SAT_EN selects saturating elements; default wraps.
module vector_accum_sched #(
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int COUNT_WIDTH    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  vector_accum_sched_if.slave  bus
);

  localparam int W = DOT_PROD_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [0:WEIGHT_COLS-1][W-1:0]  acc_q, acc_d;
  logic [COUNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic                           ovf_q, ovf_d;
  logic [W:0]                     sum [WEIGHT_COLS];
  logic                           beat;

  assign beat = (state_q == ACCUM) && bus.in_valid;

  // Per-element widened sums; the top bit is the carry-out
  always_comb begin
    for (int i = 0; i < WEIGHT_COLS; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, bus.in_vector[i]};
    end
  end

  // Next-state, accumulator, count and overflow update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = bus.num_vecs;
          state_d = (bus.num_vecs == '0) ? OUTPUT : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          for (int i = 0; i < WEIGHT_COLS; i++) begin
`ifdef VEC_ACC_SAT_EN
            acc_d[i] = sum[i][W] ? {W{1'b1}} : sum[i][W-1:0];
`else
            acc_d[i] = sum[i][W-1:0];
`endif
            if (sum[i][W]) ovf_d = 1'b1;
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == {{(COUNT_WIDTH-1){1'b0}}, 1'b1})
            state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready   = (state_q == ACCUM);
  assign bus.out_valid  = (state_q == OUTPUT);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_vector = acc_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_vector_accum_sched.sv
// Directed bench for vector_accum_sched.
// Inputs change 1 time unit after the rising edge; checks sample there too.
module tb_vector_accum_sched;

  typedef logic [0:2][15:0] vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  vector_accum_sched_if #(
    .WEIGHT_COLS(3), .DOT_PROD_WIDTH(16), .COUNT_WIDTH(5)
  ) bus ();

  vector_accum_sched #(
    .WEIGHT_COLS(3), .DOT_PROD_WIDTH(16), .COUNT_WIDTH(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [15:0] a,
                              input logic [15:0] b,
                              input logic [15:0] c);
    vec_t v;
    v[0] = a;
    v[1] = b;
    v[2] = c;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  vec_t held;
  vec_t ovf_exp;

  initial begin
    checks   = 0;
    failures = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.num_vecs  = '0;
    bus.in_valid  = 1'b0;
    bus.in_vector = '0;
    bus.out_ready = 1'b0;

    // Reset for 3 cycles, then idle
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_vector", bus.out_vector, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_busy", bus.busy, 0);

    // Basic job, no stalls
    bus.out_ready = 1'b1;
    bus.num_vecs  = 5'd3;
    bus.start     = 1'b1;
    tick();
    check("basic_in_ready", bus.in_ready, 1);
    check("basic_busy", bus.busy, 1);
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_vector = mk(1, 2, 3);
    tick();
    bus.in_vector = mk(10, 20, 30);
    tick();
    check("basic_no_early_valid", bus.out_valid, 0);
    bus.in_vector = mk(100, 200, 300);
    tick();
    check("basic_out_valid", bus.out_valid, 1);
    check("basic_in_ready_low", bus.in_ready, 0);
    check("basic_sum", bus.out_vector, mk(111, 222, 333));
    check("basic_overflow", bus.overflow, 0);
    bus.in_valid = 1'b0;
    tick();
    check("basic_idle_valid", bus.out_valid, 0);
    check("basic_idle_busy", bus.busy, 0);

    // Input stalls, ignored starts, output back-pressure
    bus.out_ready = 1'b0;
    bus.num_vecs  = 5'd2;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_vector = mk(7, 8, 9);
    tick();
    bus.in_valid  = 1'b0;
    bus.in_vector = mk(500, 500, 500);
    bus.start     = 1'b1;
    bus.num_vecs  = 5'd5;
    tick();
    check("stall_hold_acc", bus.out_vector, mk(7, 8, 9));
    check("stall_in_ready", bus.in_ready, 1);
    bus.start = 1'b0;
    tick();
    bus.in_valid  = 1'b1;
    bus.in_vector = mk(1, 1, 1);
    tick();
    check("stall_out_valid", bus.out_valid, 1);
    check("stall_sum", bus.out_vector, mk(8, 9, 10));
    held          = bus.out_vector;
    bus.in_vector = mk(100, 100, 100);
    bus.start     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold_valid", bus.out_valid, 1);
      check("stall_hold_vec", bus.out_vector, mk(8, 9, 10));
    end
    check("stall_in_ready_low", bus.in_ready, 0);
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("stall_idle_valid", bus.out_valid, 0);
    check("stall_idle_busy", bus.busy, 0);
    tick();
    check("stall_no_queued_start", bus.busy, 0);
    check("stall_acc_kept", bus.out_vector, held);

    // Zero-length job
    bus.num_vecs = 5'd0;
    bus.start    = 1'b1;
    tick();
    check("zero_out_valid", bus.out_valid, 1);
    check("zero_in_ready", bus.in_ready, 0);
    check("zero_vec", bus.out_vector, 0);
    bus.start = 1'b0;
    tick();
    check("zero_idle_valid", bus.out_valid, 0);
    check("zero_idle_in_ready", bus.in_ready, 0);

    // Overflow in element 0
`ifdef VEC_ACC_SAT_EN
    ovf_exp = mk(16'hFFFF, 2, 0);
`else
    ovf_exp = mk(16'h0001, 2, 0);
`endif
    bus.num_vecs = 5'd2;
    bus.start    = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_vector = mk(16'hFFFF, 1, 0);
    tick();
    check("ovf_not_yet", bus.overflow, 0);
    bus.in_vector = mk(2, 1, 0);
    tick();
    bus.in_valid = 1'b0;
    check("ovf_out_valid", bus.out_valid, 1);
    check("ovf_vec", bus.out_vector, ovf_exp);
    check("ovf_flag", bus.overflow, 1);
    tick();
    check("ovf_sticky_idle", bus.overflow, 1);

    // New job clears overflow; reset after 2 of 4 beats
    bus.num_vecs = 5'd4;
    bus.start    = 1'b1;
    tick();
    check("ovf_cleared", bus.overflow, 0);
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_vector = mk(9, 9, 9);
    repeat (2) tick();
    check("mid_partial", bus.out_vector, mk(18, 18, 18));
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_busy", bus.busy, 0);
    check("mid_in_ready", bus.in_ready, 0);
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_vec_cleared", bus.out_vector, 0);
    bus.num_vecs = 5'd1;
    bus.start    = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_vector = mk(5, 5, 5);
    tick();
    bus.in_valid = 1'b0;
    check("post_rst_valid", bus.out_valid, 1);
    check("post_rst_vec", bus.out_vector, mk(5, 5, 5));
    tick();
    check("post_rst_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
